// File: rtl/present_round_ctrl.sv
// PRESENT-80 round controller: one cipher round per clock, IDLE/ROUND/FINAL/DONE handshake.
// Define PRESENT_KEY128_EN to build the 128-bit key variant instead of the 80-bit default.

module present_sbox (
  input  logic [3:0] in_nib,
  output logic [3:0] out_nib
);
  always_comb begin
    case (in_nib)
      4'h0: out_nib = 4'hC;  4'h1: out_nib = 4'h5;  4'h2: out_nib = 4'h6;  4'h3: out_nib = 4'hB;
      4'h4: out_nib = 4'h9;  4'h5: out_nib = 4'h0;  4'h6: out_nib = 4'hA;  4'h7: out_nib = 4'hD;
      4'h8: out_nib = 4'h3;  4'h9: out_nib = 4'hE;  4'hA: out_nib = 4'hF;  4'hB: out_nib = 4'h8;
      4'hC: out_nib = 4'h4;  4'hD: out_nib = 4'h7;  4'hE: out_nib = 4'h1;  default: out_nib = 4'h2;
    endcase
  end
endmodule

module present_sbox_layer (
  input  logic [63:0] in_data,
  output logic [63:0] out_data
);
  for (genvar n = 0; n < 16; n++) begin : g_nib
    present_sbox u_sbox (.in_nib(in_data[4*n +: 4]), .out_nib(out_data[4*n +: 4]));
  end
endmodule

module present_round_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inStart,
  input  logic [63:0] inData,
`ifdef PRESENT_KEY128_EN
  input  logic [127:0] inKey,
`else
  input  logic [79:0]  inKey,
`endif
  input  logic        inAck,
  output logic [63:0] outData,
  output logic        outValid,
  output logic        outBusy
);
`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

  fsm_e          state_q, state_d;
  logic [63:0]   data_q, data_d;
  logic [KW-1:0] key_q, key_d;
  logic [4:0]    ctr_q, ctr_d;

  logic [63:0]   round_key, sbox_in, sbox_out, perm_out;
  logic [KW-1:0] key_rot, key_next;
  logic [3:0]    key_sbox_hi;

  assign round_key = key_q[KW-1 -: 64];
  assign sbox_in   = data_q ^ round_key;

  present_sbox_layer u_sbox_layer (.in_data(sbox_in), .out_data(sbox_out));

  // Bit i lands at (16*i) mod 63; bit 63 is fixed.
  for (genvar i = 0; i < 63; i++) begin : g_perm
    assign perm_out[(16*i) % 63] = sbox_out[i];
  end
  assign perm_out[63] = sbox_out[63];

  assign key_rot = {key_q[KW-62:0], key_q[KW-1:KW-61]};

  present_sbox u_key_sbox_hi (.in_nib(key_rot[KW-1 -: 4]), .out_nib(key_sbox_hi));

`ifdef PRESENT_KEY128_EN
  logic [3:0] key_sbox_lo;
  present_sbox u_key_sbox_lo (.in_nib(key_rot[KW-5 -: 4]), .out_nib(key_sbox_lo));

  always_comb begin
    key_next           = key_rot;
    key_next[127:124]  = key_sbox_hi;
    key_next[123:120]  = key_sbox_lo;
    key_next[66:62]    = key_rot[66:62] ^ ctr_q;
  end
`else
  always_comb begin
    key_next         = key_rot;
    key_next[79:76]  = key_sbox_hi;
    key_next[19:15]  = key_rot[19:15] ^ ctr_q;
  end
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    case (state_q)
      IDLE: begin
        if (inStart) begin
          data_d  = inData;
          key_d   = inKey;
          ctr_d   = 5'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = perm_out;
        key_d  = key_next;
        if (ctr_q == 5'd31) begin
          state_d = FINAL;
        end else begin
          ctr_d = ctr_q + 5'd1;
        end
      end
      FINAL: begin
        data_d  = sbox_in;
        state_d = DONE;
      end
      DONE: begin
        if (inAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    outValid = (state_q == DONE);
    outBusy  = (state_q == ROUND) || (state_q == FINAL);
    outData  = outValid ? data_q : '0;
  end
endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: algorithmic PRESENT model plus cycle-count handshake model.
// Honours PRESENT_KEY128_EN the same way the design does.

module tb_present_round_ctrl;
`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inStart = 1'b0;
  logic [63:0]   inData = '0;
  logic [KW-1:0] inKey = '0;
  logic          inAck = 1'b0;
  logic [63:0]   outData;
  logic          outValid;
  logic          outBusy;

  int checks = 0;
  int failures = 0;

  present_round_ctrl dut (
    .clk(clk), .rst(rst), .inStart(inStart), .inData(inData),
    .inKey(inKey), .inAck(inAck), .outData(outData),
    .outValid(outValid), .outBusy(outBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cipher reference ----------------
  logic [3:0] sbox_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [KW-1:0] k);
    logic [63:0]   s, t;
    logic [KW-1:0] key;
    int            d;
    s = pt;
    key = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ key[KW-1 -: 64];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sbox_tbl[s[4*n +: 4]];
      for (int i = 0; i < 64; i++) begin
        d = (i == 63) ? 63 : (16 * i) % 63;
        s[d] = t[i];
      end
      key = (key << 61) | (key >> (KW - 61));
      key[KW-1 -: 4] = sbox_tbl[key[KW-1 -: 4]];
`ifdef PRESENT_KEY128_EN
      key[KW-5 -: 4] = sbox_tbl[key[KW-5 -: 4]];
      key[66:62] = key[66:62] ^ 5'(r);
`else
      key[19:15] = key[19:15] ^ 5'(r);
`endif
    end
    return s ^ key[KW-1 -: 64];
  endfunction

  // ---------------- handshake reference ----------------
  // m_cnt = edges since acceptance while busy (0 when not busy).
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_done) begin
      if (inAck) m_done <= 1'b0;
    end else if (m_cnt == 32) begin
      m_cnt  <= 0;
      m_done <= 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt + 1;
    end else if (inStart) begin
      m_cnt <= 1;
      m_res <= model_enc(inData, inKey);
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(outBusy), 64'(m_cnt > 0));
    check("valid", 64'(outValid), 64'(m_done));
    check("data", outData, m_done ? m_res : 64'h0);
  end

  // ---------------- stimulus ----------------
  task automatic rand_inputs();
    logic [127:0] r128;
    r128 = {$urandom, $urandom, $urandom, $urandom};
    inData = {$urandom, $urandom};
    inKey = r128[KW-1:0];
  endtask

  task automatic run_vector(input string name, input logic [63:0] pt, input logic [KW-1:0] key,
                            input logic [63:0] exp, input bit hold_start, input int ack_delay);
    int lat;
    @(negedge clk);
    inStart = 1'b1;
    inData = pt;
    inKey = key;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!hold_start) begin
        inStart = 1'b0;
        rand_inputs();
      end
      if (outValid) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_result"}, outData, exp);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      check({name, "_hold"}, outData, exp);
    end
    inAck = 1'b1;
    @(negedge clk);
    inAck = 1'b0;
    inStart = 1'b0;
    check({name, "_ack_valid"}, 64'(outValid), 64'd0);
    @(negedge clk);
    check({name, "_idle_busy"}, 64'(outBusy), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_data", outData, 64'h0);
    check("rst_valid", 64'(outValid), 64'd0);
    check("rst_busy", 64'(outBusy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifdef PRESENT_KEY128_EN
    check("model_k128_zero", model_enc(64'h0, '0), 64'h96DB702A2E6900AF);
    run_vector("vec_zero", 64'h0, '0, 64'h96DB702A2E6900AF, 1'b0, 0);
    run_vector("vec_ones", 64'hFFFFFFFFFFFFFFFF, '1, model_enc(64'hFFFFFFFFFFFFFFFF, '1), 1'b1, 10);
`else
    check("model_zero", model_enc(64'h0, '0), 64'h5579C1387B228445);
    check("model_ones", model_enc(64'hFFFFFFFFFFFFFFFF, '1), 64'h3333DCD3213210D2);
    run_vector("vec_zero", 64'h0, '0, 64'h5579C1387B228445, 1'b0, 0);
    run_vector("vec_ones", 64'hFFFFFFFFFFFFFFFF, '1, 64'h3333DCD3213210D2, 1'b1, 10);
    run_vector("vec_zk1", 64'h0, '1, 64'hE72C46C0F5945049, 1'b0, 3);
`endif

    // Abort a run at E15 with an asynchronous reset.
    @(negedge clk);
    inStart = 1'b1;
    inData = 64'h0123456789ABCDEF;
    inKey = '1;
    repeat (16) @(posedge clk);
    inStart = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_data", outData, 64'h0);
    check("abort_valid", 64'(outValid), 64'd0);
    check("abort_busy", 64'(outBusy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef PRESENT_KEY128_EN
    run_vector("post_rst", 64'hFFFFFFFFFFFFFFFF, '0, model_enc(64'hFFFFFFFFFFFFFFFF, '0), 1'b0, 2);
`else
    run_vector("post_rst", 64'hFFFFFFFFFFFFFFFF, '0, 64'hA112FFC72F68417B, 1'b0, 2);
`endif

    // Random traffic: stray starts/acks, changing data/key, occasional resets.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      inStart = ($urandom_range(0, 3) == 0);
      inAck = ($urandom_range(0, 2) == 0);
      rand_inputs();
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    inStart = 1'b0;
    inAck = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/present_round_ctrl.md
PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

Interface
REQ-001 Parameters: none; round count fixed at 31 per the PRESENT cipher.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 inStart  input  1  request to encrypt inData under inKey; sampled only in IDLE.
REQ-005 inData  input  64  plaintext; captured on the accepting edge.
REQ-006 inKey  input  80 (128 with PRESENT_KEY128_EN)  cipher key; captured on the accepting edge.
REQ-007 inAck  input  1  consumer has taken outData; sampled only in DONE.
REQ-008 outData  output  64  ciphertext; zero whenever outValid=0.
REQ-009 outValid  output  1  high only in DONE.
REQ-010 outBusy  output  1  high in ROUND and FINAL.

Function
REQ-011 FSM states: IDLE, ROUND, FINAL, DONE; state, 64-bit state register, key register, 5-bit round counter ctr, all registered.
REQ-012 IDLE & inStart=1: state<=inData, key<=inKey, ctr<=1, go ROUND; IDLE & inStart=0: hold.
REQ-013 ROUND, each edge: state<=P(S(state ^ rk)), rk = top 64 key bits; key<=schedule(key, ctr); ctr<=ctr+1.
REQ-014 S = 16 parallel PRESENT 4-bit S-boxes on nibbles [63:60]..[3:0]; shared existing S-box layer block instantiated, not re-coded.
REQ-015 P = PRESENT bit permutation: bit i moves to (16*i) mod 63 for i<63, bit 63 stays.
REQ-016 80-bit schedule: rotate left 61; S-box on [79:76]; [19:15] ^= ctr.
REQ-017 ROUND with ctr=31: perform round 31, go FINAL; ctr does not wrap past 31 (5-bit, never reaches 0 in ROUND).
REQ-018 FINAL, one edge: state<=state ^ rk (round key 32), go DONE.
REQ-019 DONE: outValid=1, outData=state; inAck=1 returns to IDLE next edge; inAck=0 holds data stable indefinitely.
REQ-020 Latency: edge E0 samples inStart; rounds on E1..E31; FINAL on E32; outValid high after E32.
REQ-021 inStart while outBusy=1 or in DONE is ignored, not queued; inData/inKey changes outside the accepting edge have no effect.
REQ-022 inAck outside DONE is ignored; inStart and inAck together in DONE: inAck honoured, inStart ignored.
REQ-023 Throughput: back-to-back requests accepted no more often than every 34 edges (E0..E32 plus ack edge).

Reset
REQ-024 rst=1 forces, asynchronously: FSM=IDLE, state=0, key=0, ctr=0, outData=0, outValid=0, outBusy=0.
REQ-025 rst mid-encryption abandons the operation; no output produced; first post-reset inStart starts cleanly.

Configuration
REQ-026 Macro PRESENT_KEY128_EN defined: inKey and key register 128 bits; rk = key[127:64]; schedule: rotate left 61, S-box on [127:124] and [123:120], [66:62] ^= ctr.
REQ-027 Macro undefined: 80-bit key only, per REQ-016; no 128-bit logic present; timing and FSM identical in both builds.

Verification
REQ-028 80-bit: inData=0, inKey=0, inStart pulse -> outValid after E32, outData=5579C1387B228445.
REQ-029 80-bit: inData=FFFFFFFFFFFFFFFF, inKey=all ones -> outData=3333DCD3213210D2; inData=0, inKey=all ones -> E72C46C0F5945049.
REQ-030 inStart held high through whole run plus inAck delayed 10 cycles -> exactly one result, outData stable 10 cycles, second encryption starts only after return to IDLE.
REQ-031 rst asserted at E15 of a run -> all outputs 0 immediately (before next edge); new request with inData=FFFFFFFFFFFFFFFF, inKey=0 -> A112FFC72F68417B.
REQ-032 PRESENT_KEY128_EN build: inData=0, inKey=0 -> outData=96DB702A2E6900AF, same latency as REQ-020.
